// File: rtl/citadel_fabric.sv
// citadel_fabric: picorv32 native memory port to on-chip SRAM, byte-stream channels and status registers.
// Optional feature: define CITADEL_FAULT_CAPTURE_EN to latch the faulting address and map it at MMIO_BASE+0x08.
module citadel_fabric #(
  parameter int unsigned SRAM_SIZE = 65536,
  parameter int unsigned N_CH      = 2,
  parameter logic [31:0] MMIO_BASE = 32'h0100_0000,
  parameter int unsigned SRAM_WAIT = 0
) (
  input  logic                r_clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic [N_CH-1:0]     ch_we,
  output logic [N_CH-1:0]     ch_re,
  output logic [31:0]         ch_wdata,
  input  logic [32*N_CH-1:0]  ch_rdata,
  input  logic [N_CH-1:0]     ch_rvalid,
  input  logic [N_CH-1:0]     ch_busy,
  input  logic [7:0]          status_in,
  output logic                panic,
  output logic [31:0]         fault_addr
);

  localparam int unsigned WORDS    = SRAM_SIZE / 4;
  localparam int unsigned WAW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic        HAS_WAIT = (SRAM_WAIT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STALL,
    S_RESP,
    S_PANIC
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   wait_cnt, wait_d;
  logic [31:0]        req_addr, req_wdata;
  logic [3:0]         req_wstrb;
  logic [31:0]        cycle_cnt;
  logic [31:0]        sram [WORDS];

  // Active request: live port while IDLE, latched copy once the request is accepted
  logic [31:0]        a_addr, a_wdata;
  logic [3:0]         a_wstrb;

  logic               is_wr, misaligned, hit_sram, hit_mmio;
  logic               hit_status, hit_cycle, hit_fcap, hit_ch, mmio_ok, fault;
  logic [5:0]         moff, ch_word;
  logic [N_CH-1:0]    ch_sel;
  logic               sel_busy, sel_rvalid;
  logic [31:0]        sel_rdata, status_word, rd_val;
  logic [WAW-1:0]     widx;

  logic               ready_d, fault_d, go_resp;
  logic [N_CH-1:0]    we_d, re_d;
  logic [31:0]        rdata_d;

  always_comb begin
    if (state == S_IDLE) begin
      a_addr  = mem_addr;
      a_wdata = mem_wdata;
      a_wstrb = mem_wstrb;
    end else begin
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
    end
  end

  // Address decode and fault classification
  always_comb begin
    is_wr      = |a_wstrb;
    misaligned = |a_addr[1:0];
    hit_sram   = a_addr < 32'(SRAM_SIZE);
    hit_mmio   = (a_addr[31:8] == MMIO_BASE[31:8]);
    moff       = a_addr[7:2];
    widx       = a_addr[WAW+1:2];
    hit_status = hit_mmio && (moff == 6'd0);
    hit_cycle  = hit_mmio && (moff == 6'd1);
`ifdef CITADEL_FAULT_CAPTURE_EN
    hit_fcap   = hit_mmio && (moff == 6'd2);
`else
    hit_fcap   = 1'b0;
`endif
    ch_word    = moff - 6'd4;
    hit_ch     = hit_mmio && (moff >= 6'd4) && (32'(ch_word) < N_CH);
    ch_sel     = '0;
    sel_busy   = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (hit_ch && (ch_word == 6'(k))) begin
        ch_sel[k]  = 1'b1;
        sel_busy   = ch_busy[k];
        sel_rvalid = ch_rvalid[k];
        sel_rdata  = ch_rdata[32*k +: 32];
      end
    end
    mmio_ok = (!is_wr && (hit_status || hit_cycle || hit_fcap)) || hit_ch;
    fault   = misaligned || !(hit_sram || mmio_ok);
  end

  always_comb begin
    status_word             = '0;
    status_word[N_CH-1:0]   = ch_rvalid;
    status_word[8 +: N_CH]  = ch_busy;
    status_word[23:16]      = status_in;
  end

  // Read data mux; writes return zero
  always_comb begin
    rd_val = '0;
    if (!is_wr) begin
      if (hit_sram)        rd_val = sram[widx];
      else if (hit_status) rd_val = status_word;
      else if (hit_cycle)  rd_val = cycle_cnt;
      else if (hit_fcap)   rd_val = fault_addr;
      else if (hit_ch)     rd_val = sel_rvalid ? sel_rdata : 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // Next state plus the values the output registers take on the way into RESP
  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    go_resp = 1'b0;
    fault_d = 1'b0;
    ready_d = 1'b0;
    we_d    = '0;
    re_d    = '0;
    rdata_d = mem_rdata;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          if (fault) begin
            state_d = S_PANIC;
            fault_d = 1'b1;
          end else if (hit_sram && HAS_WAIT) begin
            state_d = S_WAIT;
            wait_d  = CNT_W'(SRAM_WAIT - 1);
          end else if (hit_ch && is_wr && sel_busy) begin
            state_d = S_STALL;
          end else begin
            go_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) go_resp = 1'b1;
        else                wait_d  = wait_cnt - CNT_W'(1);
      end
      S_STALL: begin
        if (!sel_busy) go_resp = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      S_PANIC: state_d = S_PANIC;
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      rdata_d = rd_val;
      we_d    = is_wr ? ch_sel : '0;
      re_d    = (!is_wr && sel_rvalid) ? ch_sel : '0;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else if (state == S_IDLE && mem_valid) begin
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
      req_wstrb <= mem_wstrb;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ch_we     <= '0;
      ch_re     <= '0;
      ch_wdata  <= '0;
      panic     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      mem_ready <= ready_d;
      mem_rdata <= rdata_d;
      ch_we     <= we_d;
      ch_re     <= re_d;
      if (|we_d) ch_wdata <= a_wdata;
      panic     <= panic | fault_d;
      if (!panic) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // SRAM contents survive reset; the write commits at the end of the RESP cycle
  always_ff @(posedge r_clk) begin
    if (rst_n && state == S_RESP && hit_sram && is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (a_wstrb[b]) sram[widx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

`ifdef CITADEL_FAULT_CAPTURE_EN
  always_ff @(posedge r_clk) begin
    if (!rst_n)       fault_addr <= '0;
    else if (fault_d) fault_addr <= a_addr;
  end
`else
  assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_citadel_fabric.sv
// Scoreboard bench for citadel_fabric: SRAM with two wait states, channel stall/pop, STATUS/CYCLE, faults and reset.
module tb_citadel_fabric;

  localparam logic [31:0] MB = 32'h0100_0000;

  logic        r_clk, rst_n, mem_valid, mem_ready, panic;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ch_wdata, fault_addr;
  logic [3:0]  mem_wstrb;
  logic [1:0]  ch_we, ch_re, ch_rvalid, ch_busy;
  logic [63:0] ch_rdata;
  logic [7:0]  status_in;

  citadel_fabric #(
    .SRAM_SIZE(4096), .N_CH(2), .MMIO_BASE(MB), .SRAM_WAIT(2)
  ) dut (
    .r_clk(r_clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ch_we(ch_we), .ch_re(ch_re), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
    .ch_rvalid(ch_rvalid), .ch_busy(ch_busy), .status_in(status_in),
    .panic(panic), .fault_addr(fault_addr)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  typedef struct {
    logic        chk;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt[2];
  int          re_cnt[2];
  logic [31:0] last_wdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer and strobe monitor
  always @(negedge r_clk) begin
    if (mem_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ready", 32'(mem_ready), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check_eq(e.tag, mem_rdata, e.rdata);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ch_we[k]) we_cnt[k]++;
      if (ch_re[k]) re_cnt[k]++;
    end
    if (|ch_we) begin
      last_wdata = ch_wdata;
      check_eq("we_with_ready", 32'(mem_ready), 32'd1);
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic chk, input logic [31:0] exp, input string tag,
                        output int lat, output logic [31:0] rd);
    exp_t e;
    e.chk = chk; e.rdata = exp; e.tag = tag;
    exp_q.push_back(e);
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge r_clk); #1;
      lat++;
    end while (!mem_ready && lat < 64);
    rd = mem_rdata;
    if (!mem_ready) begin
      check_eq({tag, "_timeout"}, 32'(mem_ready), 32'd1);
      exp_q.delete();
    end
    mem_valid = 1'b0;
    @(posedge r_clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; mem_valid = 1'b0;
    repeat (2) @(posedge r_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fault_req(input logic [31:0] addr, input logic [3:0] wstrb, input string tag);
    int we0, re0;
    logic [31:0] exp_fa;
`ifdef CITADEL_FAULT_CAPTURE_EN
    exp_fa = addr;
`else
    exp_fa = 32'd0;
`endif
    we0 = we_cnt[0] + we_cnt[1];
    re0 = re_cnt[0] + re_cnt[1];
    mem_addr = addr; mem_wstrb = wstrb; mem_wdata = 32'h0000_1234; mem_valid = 1'b1;
    @(posedge r_clk); #1;
    check_eq({tag, "_panic"}, 32'(panic), 32'd1);
    repeat (6) @(posedge r_clk);
    #1;
    check_eq({tag, "_sticky"}, 32'(panic), 32'd1);
    check_eq({tag, "_fault_addr"}, fault_addr, exp_fa);
    check_eq({tag, "_no_strobe"}, 32'(we_cnt[0] + we_cnt[1] + re_cnt[0] + re_cnt[1]), 32'(we0 + re0));
    apply_reset();
    check_eq({tag, "_panic_clr"}, 32'(panic), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd, c1, c2;
  int          we_snap;

  initial begin
    we_cnt = '{0, 0}; re_cnt = '{0, 0};
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    ch_rdata = '0; ch_rvalid = '0; ch_busy = '0; status_in = '0;
    repeat (3) @(posedge r_clk);
    #1 rst_n = 1'b1;
    @(negedge r_clk);
    check_eq("rst_ready", 32'(mem_ready), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_we", 32'(ch_we), 32'd0);
    check_eq("rst_re", 32'(ch_re), 32'd0);
    check_eq("rst_wdata", ch_wdata, 32'd0);
    check_eq("rst_panic", 32'(panic), 32'd0);
    check_eq("rst_fault_addr", fault_addr, 32'd0);
    @(posedge r_clk); #1;

    // SRAM byte lanes with two wait states
    do_req(32'h100, 32'h0, 4'hF, 1'b0, 32'h0, "wr_clear", lat, rd);
    do_req(32'h100, 32'hDEADBEEF, 4'b0101, 1'b0, 32'h0, "wr_0101", lat, rd);
    check_eq("sram_wr_lat", 32'(lat), 32'd3);
    do_req(32'h100, 32'h0, 4'h0, 1'b1, 32'h00AD00EF, "rd_0101", lat, rd);
    check_eq("sram_rd_lat", 32'(lat), 32'd3);
    do_req(32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0, "wr_full", lat, rd);
    do_req(32'h200, 32'hAABBCCDD, 4'b1010, 1'b0, 32'h0, "wr_1010", lat, rd);
    do_req(32'h200, 32'h0, 4'h0, 1'b1, 32'hAA34CC78, "rd_1010", lat, rd);
    do_req(32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, "wr_last", lat, rd);
    do_req(32'hFFC, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, "rd_last", lat, rd);

    // STATUS and CYCLE
    ch_rvalid = 2'b10; ch_busy = 2'b01; status_in = 8'h0C;
    do_req(MB, 32'h0, 4'h0, 1'b1, 32'h000C0102, "status", lat, rd);
    check_eq("mmio_lat", 32'(lat), 32'd1);
    ch_rvalid = 2'b00; ch_busy = 2'b00; status_in = 8'h00;
    do_req(MB + 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, "cycle_a", lat, c1);
    do_req(MB + 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, "cycle_b", lat, c2);
    check_eq("cycle_delta", c2 - c1, 32'd2);

    // Channel pops
    do_req(MB + 32'h10, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF, "ch0_empty", lat, rd);
    check_eq("ch0_empty_no_re", 32'(re_cnt[0]), 32'd0);
    ch_rvalid = 2'b01; ch_rdata[31:0] = 32'h5A;
    do_req(MB + 32'h10, 32'h0, 4'h0, 1'b1, 32'h5A, "ch0_pop", lat, rd);
    check_eq("ch0_re_pulse", 32'(re_cnt[0]), 32'd1);
    check_eq("ch1_no_re", 32'(re_cnt[1]), 32'd0);
    ch_rvalid = 2'b00;

    // Channel writes, then one held off by busy for five cycles
    do_req(MB + 32'h10, 32'h33, 4'hF, 1'b0, 32'h0, "ch0_wr", lat, rd);
    check_eq("ch0_wr_lat", 32'(lat), 32'd1);
    check_eq("ch0_we_cnt", 32'(we_cnt[0]), 32'd1);
    check_eq("ch0_wdata", last_wdata, 32'h33);
    ch_busy = 2'b10;
    fork
      do_req(MB + 32'h14, 32'h41, 4'hF, 1'b0, 32'h0, "ch1_stall", lat, rd);
      begin
        repeat (5) @(posedge r_clk);
        #1;
        check_eq("ch1_no_we_while_busy", 32'(we_cnt[1]), 32'd0);
        ch_busy = 2'b00;
      end
    join
    check_eq("ch1_stall_lat", 32'(lat), 32'd6);
    check_eq("ch1_we_cnt", 32'(we_cnt[1]), 32'd1);
    check_eq("ch1_wdata", last_wdata, 32'h41);

    // Reset in the middle of a STALL
    we_snap = we_cnt[1];
    ch_busy = 2'b10;
    mem_addr = MB + 32'h14; mem_wdata = 32'h99; mem_wstrb = 4'hF; mem_valid = 1'b1;
    repeat (3) @(posedge r_clk);
    #1 rst_n = 1'b0; mem_valid = 1'b0;
    @(posedge r_clk); #1;
    rst_n = 1'b1; ch_busy = 2'b00;
    check_eq("stall_rst_ready", 32'(mem_ready), 32'd0);
    check_eq("stall_rst_panic", 32'(panic), 32'd0);
    repeat (3) @(posedge r_clk);
    #1;
    check_eq("stall_rst_no_we", 32'(we_cnt[1]), 32'(we_snap));
    do_req(32'h100, 32'h0, 4'h0, 1'b1, 32'h00AD00EF, "sram_retained", lat, rd);

    // Faults
    fault_req(32'h0000_0102, 4'h0, "misaligned");
    fault_req(MB, 4'hF, "status_write");
    fault_req(MB + 32'h4, 4'h1, "cycle_write");
    fault_req(32'h0000_1000, 4'h0, "past_sram");
    fault_req(MB + 32'h18, 4'h0, "past_channels");
`ifdef CITADEL_FAULT_CAPTURE_EN
    do_req(MB + 32'h8, 32'h0, 4'h0, 1'b1, 32'h0, "fault_addr_reg", lat, rd);
`else
    fault_req(MB + 32'h8, 4'h0, "fault_addr_unmapped");
`endif
    do_req(32'h200, 32'h0, 4'h0, 1'b1, 32'hAA34CC78, "post_fault_rd", lat, rd);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
